// File: rtl/can_opb_pkg.sv
// Shared types and default CAN channel register map for the OPB RX master
// and the CAN channel wrapper.
package can_opb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_STAT,
    RD_ID,
    RD_D0,
    RD_D1,
    WR_ACK,
    HOLD
  } rx_state_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] id;
    logic [31:0] d0;
    logic [31:0] d1;
  } can_frame_t;

  localparam logic [15:0] CAN_STAT_ADDR  = 16'h0000;
  localparam logic [15:0] CAN_ID_ADDR    = 16'h0004;
  localparam logic [15:0] CAN_D0_ADDR    = 16'h0008;
  localparam logic [15:0] CAN_D1_ADDR    = 16'h000C;
  localparam logic [15:0] CAN_ACK_ADDR   = 16'h0010;
  localparam logic [31:0] CAN_RX_RELEASE = 32'h0000_0001;

endpackage

// File: rtl/opb_access_seq.sv
// Single OPB access engine: issues one registered RE or WE strobe to the
// selected channel and signals done when read data (or the write) is complete.
module opb_access_seq #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [15:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [1:0]       channel,
  input  logic [3:0][31:0] ch_rdata,
  output logic [3:0]       re,
  output logic [3:0]       we,
  output logic [15:0]      opb_addr,
  output logic [31:0]      opb_wdata,
  output logic             done,
  output logic [31:0]      rdata
);

  localparam logic [2:0] RD_LAST = 3'(RD_LAT + 1);

  logic       busy;
  logic       wr;
  logic [2:0] cnt;
  logic [1:0] ch_q;

  // cnt is 1 in the strobe cycle, so a read completes RD_LAT cycles later
  assign done  = busy && (wr ? (cnt == 3'd1) : (cnt == RD_LAST));
  assign rdata = ch_rdata[ch_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      wr        <= 1'b0;
      cnt       <= '0;
      ch_q      <= '0;
      re        <= '0;
      we        <= '0;
      opb_addr  <= '0;
      opb_wdata <= '0;
    end else begin
      re <= '0;
      we <= '0;
      if (start) begin
        busy     <= 1'b1;
        wr       <= rw;
        cnt      <= 3'd1;
        ch_q     <= channel;
        opb_addr <= addr;
        if (rw) begin
          opb_wdata   <= wdata;
          we[channel] <= 1'b1;
        end else begin
          re[channel] <= 1'b1;
        end
      end else if (done) begin
        busy <= 1'b0;
      end else if (busy) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/can_opb_rx_master.sv
// OPB initiator that round-robin polls four CAN channels, drains pending RX
// frames, releases the channel buffer and offers each frame on a valid/ready stream.
module can_opb_rx_master
  import can_opb_pkg::*;
#(
  parameter logic [15:0] STAT_ADDR = CAN_STAT_ADDR,
  parameter logic [15:0] ID_ADDR   = CAN_ID_ADDR,
  parameter logic [15:0] D0_ADDR   = CAN_D0_ADDR,
  parameter logic [15:0] D1_ADDR   = CAN_D1_ADDR,
  parameter logic [15:0] ACK_ADDR  = CAN_ACK_ADDR,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        ENABLE,
  output logic [15:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  output logic        CAN1_RE,
  output logic        CAN2_RE,
  output logic        CAN3_RE,
  output logic        CAN4_RE,
  output logic        CAN1_WE,
  output logic        CAN2_WE,
  output logic        CAN3_WE,
  output logic        CAN4_WE,
  input  logic [31:0] CAN1_DO,
  input  logic [31:0] CAN2_DO,
  input  logic [31:0] CAN3_DO,
  input  logic [31:0] CAN4_DO,
  output logic        FRM_VALID,
  input  logic        FRM_READY,
  output logic [1:0]  FRM_CH,
  output logic [31:0] FRM_ID,
  output logic [31:0] FRM_D0,
  output logic [31:0] FRM_D1,
  output logic [15:0] FRM_CNT
);

  rx_state_t        state;
  logic [1:0]       ptr;
  can_frame_t       frm;
  logic             frm_valid;
  logic [15:0]      frm_cnt;

  logic             acc_start;
  logic             acc_rw;
  logic [15:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_done;
  logic [31:0]      acc_rdata;
  logic [3:0]       re;
  logic [3:0]       we;
  logic [3:0][31:0] can_do;

  assign can_do = {CAN4_DO, CAN3_DO, CAN2_DO, CAN1_DO};

  opb_access_seq #(
    .RD_LAT(RD_LAT)
  ) u_access (
    .clk      (OPB_CLK),
    .rst      (OPB_RST),
    .start    (acc_start),
    .rw       (acc_rw),
    .addr     (acc_addr),
    .wdata    (acc_wdata),
    .channel  (ptr),
    .ch_rdata (can_do),
    .re       (re),
    .we       (we),
    .opb_addr (OPB_ADDR),
    .opb_wdata(OPB_DO),
    .done     (acc_done),
    .rdata    (acc_rdata)
  );

  // Next access is launched in the completion cycle of the previous one so
  // back-to-back accesses leave no bubble between capture and the next strobe.
  always_comb begin
    acc_start = 1'b0;
    acc_rw    = 1'b0;
    acc_addr  = STAT_ADDR;
    acc_wdata = '0;
    case (state)
      IDLE:    acc_start = ENABLE && !frm_valid;
      RD_STAT: begin
        acc_start = acc_done && acc_rdata[0];
        acc_addr  = ID_ADDR;
      end
      RD_ID: begin
        acc_start = acc_done;
        acc_addr  = D0_ADDR;
      end
      RD_D0: begin
        acc_start = acc_done;
        acc_addr  = D1_ADDR;
      end
      RD_D1: begin
        acc_start = acc_done;
        acc_rw    = 1'b1;
        acc_addr  = ACK_ADDR;
        acc_wdata = CAN_RX_RELEASE;
      end
      default: acc_start = 1'b0;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state     <= IDLE;
      ptr       <= '0;
      frm       <= '0;
      frm_valid <= 1'b0;
      frm_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (ENABLE && !frm_valid) state <= RD_STAT;
        RD_STAT: if (acc_done) begin
          if (acc_rdata[0]) begin
            state <= RD_ID;
          end else begin
            ptr   <= ptr + 2'd1;
            state <= IDLE;
          end
        end
        RD_ID: if (acc_done) begin
          frm.id <= acc_rdata;
          state  <= RD_D0;
        end
        RD_D0: if (acc_done) begin
          frm.d0 <= acc_rdata;
          state  <= RD_D1;
        end
        RD_D1: if (acc_done) begin
          frm.d1 <= acc_rdata;
          state  <= WR_ACK;
        end
        WR_ACK: if (acc_done) begin
          frm.ch    <= ptr;
          frm_valid <= 1'b1;
          ptr       <= ptr + 2'd1;
          state     <= HOLD;
        end
        HOLD: if (frm_valid && FRM_READY) begin
          frm_valid <= 1'b0;
          frm_cnt   <= frm_cnt + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {CAN4_RE, CAN3_RE, CAN2_RE, CAN1_RE} = re;
  assign {CAN4_WE, CAN3_WE, CAN2_WE, CAN1_WE} = we;
  assign FRM_VALID = frm_valid;
  assign FRM_CH    = frm.ch;
  assign FRM_ID    = frm.id;
  assign FRM_D0    = frm.d0;
  assign FRM_D1    = frm.d1;
  assign FRM_CNT   = frm_cnt;

endmodule

// File: tb/tb_can_opb_rx_master.sv
// Bench for can_opb_rx_master: behavioural CAN channel model with configurable
// read latency, two DUTs (RD_LAT=1 and RD_LAT=3), per-scenario checking tasks.
module tb_can_opb_rx_master;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] d0;
    logic [31:0] d1;
  } fr_t;

  typedef struct {
    int          inst;
    int          ch;
    logic [15:0] a;
    logic [31:0] d;
    int unsigned cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en  [2];
  logic        rdy [2];
  logic [3:0]  re  [2];
  logic [3:0]  we  [2];
  logic [15:0] addr[2];
  logic [31:0] wdo [2];
  logic [31:0] din [2][4];
  logic        fv  [2];
  logic [1:0]  fch [2];
  logic [31:0] fid [2];
  logic [31:0] fd0 [2];
  logic [31:0] fd1 [2];
  logic [15:0] fcnt[2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    can_opb_rx_master #(
      .RD_LAT(g == 0 ? 1 : 3)
    ) u_dut (
      .OPB_CLK  (clk),
      .OPB_RST  (rst),
      .ENABLE   (en[g]),
      .OPB_ADDR (addr[g]),
      .OPB_DO   (wdo[g]),
      .CAN1_RE  (re[g][0]),
      .CAN2_RE  (re[g][1]),
      .CAN3_RE  (re[g][2]),
      .CAN4_RE  (re[g][3]),
      .CAN1_WE  (we[g][0]),
      .CAN2_WE  (we[g][1]),
      .CAN3_WE  (we[g][2]),
      .CAN4_WE  (we[g][3]),
      .CAN1_DO  (din[g][0]),
      .CAN2_DO  (din[g][1]),
      .CAN3_DO  (din[g][2]),
      .CAN4_DO  (din[g][3]),
      .FRM_VALID(fv[g]),
      .FRM_READY(rdy[g]),
      .FRM_CH   (fch[g]),
      .FRM_ID   (fid[g]),
      .FRM_D0   (fd0[g]),
      .FRM_D1   (fd1[g]),
      .FRM_CNT  (fcnt[g])
    );
  end

  // ---------------- channel model ----------------
  fr_t         cur  [2][4];
  bit          pend [2][4];
  bit          rearm;
  logic [31:0] sv   [2][4][8];
  bit          sval [2][4][8];
  fr_t         exp_q[4][$];
  ev_t         re_log[$];
  ev_t         we_log[$];
  int unsigned cyc = 0;
  int unsigned viol = 0;
  int unsigned slot;

  function automatic int unsigned lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] reg_val(int i, int c, logic [15:0] a);
    case (a)
      16'h0000: return {31'd0, pend[i][c]};
      16'h0004: return cur[i][c].id;
      16'h0008: return cur[i][c].d0;
      16'h000C: return cur[i][c].d1;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic fr_t rnd_fr();
    fr_t f;
    f.id = $urandom;
    f.d0 = $urandom;
    f.d1 = $urandom;
    return f;
  endfunction

  always @(posedge clk) cyc++;

  // Read data is only valid exactly RD_LAT cycles after the strobe; other
  // cycles carry a filler word with bit0 clear.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ($countones({re[i], we[i]}) > 1) viol++;
      for (int c = 0; c < 4; c++) begin
        if (rst) begin
          for (int k = 0; k < 8; k++) sval[i][c][k] = 1'b0;
        end else begin
          if (re[i][c]) begin
            slot = (cyc + lat_of(i)) % 8;
            sv[i][c][slot]   = reg_val(i, c, addr[i]);
            sval[i][c][slot] = 1'b1;
            re_log.push_back('{i, c, addr[i], 32'h0, cyc});
          end
          if (we[i][c]) begin
            we_log.push_back('{i, c, addr[i], wdo[i], cyc});
            if (addr[i] == 16'h0010 && wdo[i] == 32'h1) begin
              pend[i][c] = 1'b0;
              if (rearm) begin
                cur[i][c]  = rnd_fr();
                pend[i][c] = 1'b1;
                if (i == 0) exp_q[c].push_back(cur[i][c]);
              end
            end
          end
        end
        slot = cyc % 8;
        din[i][c] = sval[i][c][slot] ? sv[i][c][slot] : 32'hA5A5_A5A4;
        sval[i][c][slot] = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst   = 1'b1;
    rearm = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) pend[i][c] = 1'b0;
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    repeat (n) tick();
    re_log.delete();
    we_log.delete();
    rst = 1'b0;
  endtask

  task automatic arm(int i, int c, fr_t f);
    cur[i][c]  = f;
    pend[i][c] = 1'b1;
    if (i == 0) exp_q[c].push_back(f);
  endtask

  task automatic wait_valid(int i, int budget, output bit ok);
    int k;
    ok = 1'b0;
    k  = 0;
    while (k < budget && !ok) begin
      if (fv[i] === 1'b1) ok = 1'b1;
      else begin
        tick();
        k++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    fr_t f;
    bit  seen;
    int  n0;
    f = rnd_fr();
    do_reset(2);
    arm(0, 0, f);
    rdy[0] = 1'b1;
    en[0]  = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      if (re[0][0] === 1'b1 && addr[0] === 16'h0008) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_reach_d0: D0 read never observed (got %0d exp 1)", seen);
    end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({re[0], we[0], fv[0], fcnt[0]} !== 25'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got re=%b we=%b valid=%b cnt=%h exp all 0", re[0], we[0], fv[0], fcnt[0]);
    end
    checks++;
    if ({fch[0], fid[0], fd0[0], fd1[0], addr[0], wdo[0]} !== '0) begin
      failures++;
      $display("FAIL reset_data: got ch=%h id=%h d0=%h d1=%h addr=%h do=%h exp 0", fch[0], fid[0], fd0[0], fd1[0], addr[0], wdo[0]);
    end
    checks++;
    if (we_log.size() != 0) begin
      failures++;
      $display("FAIL reset_no_ack: got %0d writes exp 0", we_log.size());
    end
    n0  = re_log.size();
    rst = 1'b0;
    for (int k = 0; k < 10 && re_log.size() == n0; k++) tick();
    checks++;
    if (re_log.size() == n0 || re_log[n0].ch != 0 || re_log[n0].a !== 16'h0000) begin
      failures++;
      $display("FAIL reset_first_poll: got %0d new reads exp CAN1 STAT read", re_log.size() - n0);
    end
    wait_valid(0, 100, seen);
    checks++;
    if (!seen || {fch[0], fid[0], fd0[0], fd1[0]} !== {2'd0, f}) begin
      failures++;
      $display("FAIL reset_represent: got v=%0d ch=%0d id=%h exp ch=0 id=%h", seen, fch[0], fid[0], f.id);
    end
    tick();
    checks++;
    if (fcnt[0] !== 16'd1 || fv[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt: got cnt=%0d valid=%b exp 1 0", fcnt[0], fv[0]);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_idle_bus();
    bit ok;
    do_reset(2);
    rdy[0] = 1'b1;
    en[0]  = 1'b1;
    for (int k = 0; k < 40 && re_log.size() < 5; k++) tick();
    en[0] = 1'b0;
    ok = (re_log.size() >= 5);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout: got %0d reads exp 5", re_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (re_log[k].inst != 0 || re_log[k].ch != (k % 4) || re_log[k].a !== 16'h0000) begin
          failures++;
          $display("FAIL idle_order%0d: got ch=%0d addr=%h exp ch=%0d addr=0000", k, re_log[k].ch, re_log[k].a, k % 4);
        end
        if (k > 0) begin
          checks++;
          if (re_log[k].cyc - re_log[k-1].cyc != 3) begin
            failures++;
            $display("FAIL idle_spacing%0d: got %0d exp 3", k, re_log[k].cyc - re_log[k-1].cyc);
          end
        end
      end
    end
    repeat (6) tick();
    checks++;
    if (we_log.size() != 0) begin
      failures++;
      $display("FAIL idle_no_we: got %0d exp 0", we_log.size());
    end
  endtask

  // Checks the read sequence and FRM_VALID latency for one frame on inst/ch.
  task automatic test_frame_timing(string nm, int i, int c, int unsigned vcyc);
    int j;
    int unsigned st;
    st = 1 + lat_of(i);
    j  = -1;
    foreach (re_log[k])
      if (re_log[k].inst == i && re_log[k].ch == c && re_log[k].a == 16'h0000) j = k;
    checks++;
    if (j < 0 || j + 3 >= re_log.size()) begin
      failures++;
      $display("FAIL %s_reads: got %0d reads exp STAT+3", nm, re_log.size());
    end else begin
      for (int m = 1; m <= 3; m++) begin
        checks++;
        if (re_log[j+m].ch != c || re_log[j+m].a !== 16'(4 * m) || re_log[j+m].cyc != re_log[j].cyc + st * m) begin
          failures++;
          $display("FAIL %s_read%0d: got addr=%h dt=%0d exp addr=%h dt=%0d", nm, m, re_log[j+m].a,
                   re_log[j+m].cyc - re_log[j].cyc, 16'(4 * m), st * m);
        end
      end
      checks++;
      if (vcyc - re_log[j].cyc != 4 * st + 1) begin
        failures++;
        $display("FAIL %s_valid_lat: got %0d exp %0d", nm, vcyc - re_log[j].cyc, 4 * st + 1);
      end
    end
  endtask

  task automatic test_single_frame();
    fr_t f;
    bit  ok;
    int unsigned vc;
    do_reset(2);
    f = '{32'h0000_0123, 32'hDEAD_BEEF, 32'h0102_0304};
    arm(0, 2, f);
    rdy[0] = 1'b0;
    en[0]  = 1'b1;
    wait_valid(0, 100, ok);
    vc    = cyc;
    en[0] = 1'b0;
    checks++;
    if (!ok || {fch[0], fid[0], fd0[0], fd1[0]} !== {2'd2, f}) begin
      failures++;
      $display("FAIL single_frame: got v=%0d ch=%0d id=%h d0=%h d1=%h exp ch=2 id=%h d0=%h d1=%h",
               ok, fch[0], fid[0], fd0[0], fd1[0], f.id, f.d0, f.d1);
    end
    test_frame_timing("single", 0, 2, vc);
    checks++;
    if (we_log.size() != 1 || we_log[0].ch != 2 || we_log[0].a !== 16'h0010 || we_log[0].d !== 32'h1) begin
      failures++;
      $display("FAIL single_ack: got %0d writes exp one CAN3 write 0010<=1", we_log.size());
    end
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    checks++;
    if (fv[0] !== 1'b0 || fcnt[0] !== 16'd1) begin
      failures++;
      $display("FAIL single_accept: got valid=%b cnt=%0d exp 0 1", fv[0], fcnt[0]);
    end
  endtask

  task automatic test_backpressure();
    fr_t f;
    bit  ok;
    int  c, errs, nre, nwe;
    do_reset(2);
    c = int'($urandom_range(0, 3));
    f = rnd_fr();
    arm(0, c, f);
    rdy[0] = 1'b0;
    en[0]  = 1'b1;
    wait_valid(0, 120, ok);
    checks++;
    if (!ok || {fch[0], fid[0], fd0[0], fd1[0]} !== {2'(c), f}) begin
      failures++;
      $display("FAIL bp_frame: got v=%0d ch=%0d id=%h exp ch=%0d id=%h", ok, fch[0], fid[0], c, f.id);
    end
    nre  = re_log.size();
    nwe  = we_log.size();
    errs = 0;
    repeat (20) begin
      tick();
      if (fv[0] !== 1'b1 || {fch[0], fid[0], fd0[0], fd1[0]} !== {2'(c), f} || re[0] !== 4'd0 || we[0] !== 4'd0)
        errs++;
    end
    checks++;
    if (errs != 0 || re_log.size() != nre || we_log.size() != nwe) begin
      failures++;
      $display("FAIL bp_stable: got %0d unstable cycles, %0d strobes exp 0 0", errs,
               re_log.size() - nre + we_log.size() - nwe);
    end
    rdy[0] = 1'b1;
    tick();
    en[0]  = 1'b0;
    checks++;
    if (fv[0] !== 1'b0 || fcnt[0] !== 16'd1) begin
      failures++;
      $display("FAIL bp_accept: got valid=%b cnt=%0d exp 0 1", fv[0], fcnt[0]);
    end
    rdy[0] = 1'b0;
  endtask

  task automatic test_fairness();
    fr_t e;
    bit  ok;
    int  nre;
    do_reset(2);
    for (int c = 0; c < 4; c++) arm(0, c, rnd_fr());
    rearm  = 1'b1;
    rdy[0] = 1'b0;
    en[0]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(0, 100, ok);
      e = exp_q[k % 4].pop_front();
      checks++;
      if (!ok || {fch[0], fid[0], fd0[0], fd1[0]} !== {2'(k % 4), e}) begin
        failures++;
        $display("FAIL fair_frame%0d: got v=%0d ch=%0d id=%h exp ch=%0d id=%h", k, ok, fch[0], fid[0], k % 4, e.id);
      end
      repeat ($urandom_range(0, 3)) tick();
      rdy[0] = 1'b1;
      tick();
      rdy[0] = 1'b0;
    end
    checks++;
    if (fcnt[0] !== 16'd5) begin
      failures++;
      $display("FAIL fair_cnt: got %0d exp 5", fcnt[0]);
    end
    // Drop ENABLE once the CAN2 sequence is under way: it must still finish.
    repeat (3) tick();
    en[0] = 1'b0;
    wait_valid(0, 60, ok);
    e = exp_q[1].pop_front();
    checks++;
    if (!ok || {fch[0], fid[0], fd0[0], fd1[0]} !== {2'd1, e}) begin
      failures++;
      $display("FAIL fair_disable_finish: got v=%0d ch=%0d id=%h exp ch=1 id=%h", ok, fch[0], fid[0], e.id);
    end
    rdy[0] = 1'b1;
    tick();
    nre = re_log.size();
    repeat (20) tick();
    checks++;
    if (re_log.size() != nre || fv[0] !== 1'b0) begin
      failures++;
      $display("FAIL fair_disable_quiet: got %0d reads valid=%b exp 0 0", re_log.size() - nre, fv[0]);
    end
    rdy[0] = 1'b0;
    rearm  = 1'b0;
  endtask

  task automatic test_rd_lat3();
    fr_t f;
    bit  ok;
    int unsigned vc;
    do_reset(2);
    f = rnd_fr();
    arm(1, 1, f);
    rdy[1] = 1'b0;
    en[1]  = 1'b1;
    wait_valid(1, 200, ok);
    vc    = cyc;
    en[1] = 1'b0;
    checks++;
    if (!ok || {fch[1], fid[1], fd0[1], fd1[1]} !== {2'd1, f}) begin
      failures++;
      $display("FAIL lat3_frame: got v=%0d ch=%0d id=%h d0=%h d1=%h exp ch=1 id=%h d0=%h d1=%h",
               ok, fch[1], fid[1], fd0[1], fd1[1], f.id, f.d0, f.d1);
    end
    test_frame_timing("lat3", 1, 1, vc);
    checks++;
    if (we_log.size() != 1 || we_log[0].inst != 1 || we_log[0].ch != 1 || we_log[0].a !== 16'h0010) begin
      failures++;
      $display("FAIL lat3_ack: got %0d writes exp one CAN2 write", we_log.size());
    end
    rdy[1] = 1'b1;
    tick();
    rdy[1] = 1'b0;
    checks++;
    if (fv[1] !== 1'b0 || fcnt[1] !== 16'd1) begin
      failures++;
      $display("FAIL lat3_accept: got valid=%b cnt=%0d exp 0 1", fv[1], fcnt[1]);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rearm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i]  = 1'b0;
      rdy[i] = 1'b0;
    end
    test_reset();
    test_idle_bus();
    test_single_frame();
    test_backpressure();
    test_fairness();
    test_rd_lat3();
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL one_strobe: got %0d multi-strobe cycles exp 0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_opb_rx_master.md
# can_opb_rx_master

OPB initiator that services the four CAN channel register banks from the other side of the bus: it drives the per-channel RE/WE strobes, address and write data, and polls each channel for received frames. When a frame is pending it reads ID and both data words, writes the RX-release register, and presents the frame on a valid/ready output stream. It sits between the CAN interface block and the frame-processing logic, so the CPU no longer has to poll the CAN channels.

## Interface
Parameters:
- STAT_ADDR, 16'h0000: channel status register; bit0 = RX frame pending.
- ID_ADDR, 16'h0004: RX frame ID register.
- D0_ADDR, 16'h0008: RX data bytes 0-3.
- D1_ADDR, 16'h000C: RX data bytes 4-7.
- ACK_ADDR, 16'h0010: RX release register; writing 32'h1 frees the channel RX buffer.
- RD_LAT, 1: cycles from RE to valid CANx_DO (range 1-3).

Ports:
- OPB_CLK  in  1  sole clock.
- OPB_RST  in  1  reset; **synchronous and active-high** (already decided).
- ENABLE  in  1  polling enable.
- OPB_ADDR  out  16  address to all channels.
- OPB_DO  out  32  write data to all channels.
- CAN1_RE..CAN4_RE  out  1 each  per-channel read strobe.
- CAN1_WE..CAN4_WE  out  1 each  per-channel write strobe.
- CAN1_DO..CAN4_DO  in  32 each  per-channel read data.
- FRM_VALID  out  1  frame available.
- FRM_READY  in  1  consumer accepts the frame.
- FRM_CH  out  2  source channel (0 = CAN1 ... 3 = CAN4).
- FRM_ID, FRM_D0, FRM_D1  out  32 each  frame contents.
- FRM_CNT  out  16  frames delivered; wraps.

## Operation
- FSM states: IDLE, RD_STAT, RD_ID, RD_D0, RD_D1, WR_ACK, HOLD.
- IDLE: if ENABLE and no frame is held, go to RD_STAT for the channel at round-robin pointer PTR.
- Read access: one cycle with CANx_RE=1 and OPB_ADDR set. CANx_DO[PTR] is then sampled RD_LAT cycles later. One access takes 1+RD_LAT cycles.
- RD_STAT: if captured bit0=0, advance PTR (3 wraps to 0) and go to IDLE. If bit0=1, go to RD_ID, then RD_D0, then RD_D1, capturing into FRM_ID, FRM_D0 and FRM_D1.
- WR_ACK: one cycle with CANx_WE=1, OPB_ADDR=ACK_ADDR and OPB_DO=32'h1. Then load FRM_CH=PTR, set FRM_VALID, advance PTR and go to HOLD.
- HOLD: stay until FRM_VALID and FRM_READY occur in the same cycle. On that cycle clear FRM_VALID, increment FRM_CNT and go to IDLE.
- Only one RE/WE strobe is asserted in any cycle, and only for channel PTR.
- OPB_ADDR and OPB_DO hold their last value when no strobe is asserted.
- ENABLE deasserted mid-sequence: the current channel sequence runs to completion, including ACK and HOLD. No new RD_STAT is started.
- FRM_ID, FRM_D0 and FRM_D1 stay stable while FRM_VALID=1.

## Timing
- Reset, on the edge where OPB_RST=1:
  - all outputs go to 0 and all strobes go low;
  - PTR=0, FRM_CNT=0, state=IDLE.
- Reset mid-access takes effect immediately. The aborted frame is not delivered and not acknowledged; the channel re-presents it on the next poll.
- With RD_LAT=1, taking the IDLE→RD_STAT transition as cycle 0:
  - RE for STAT in cycle 1;
  - ID, D0 and D1 REs in cycles 3, 5 and 7;
  - WE for ACK in cycle 9;
  - FRM_VALID high from cycle 10.
- Empty poll with RD_LAT=1: 3 cycles per channel (IDLE, RE, capture).
- FRM_READY=1 in the first cycle FRM_VALID is high: the frame is accepted that cycle and IDLE follows on the next cycle.
- FRM_CNT increments on the accept edge only; 16'hFFFF+1 = 0.

## Structure
- Package can_opb_pkg holds:
  - the state enum;
  - a frame struct (ch, id, d0, d1);
  - the default register address constants, shared with the CAN wrapper.
- Sub-module opb_access_seq: a single read/write access engine.
  - Inputs: start, rw, addr, wdata, channel.
  - Outputs: strobes, done, rdata, with RD_LAT handled internally.
  - The top-level FSM sequences it.

## Test plan
- Reset: hold OPB_RST for 3 cycles mid-RD_D0 → all strobes 0, FRM_VALID=0, FRM_CNT=0; the next poll starts on CAN1 STAT.
- Idle bus: ENABLE=1 with all status words 0 → STAT reads on CAN1,2,3,4,1 in order, every 3 cycles, and no WE asserted.
- Single frame: CAN3 status=1, ID=32'h0000_0123, D0=32'hDEAD_BEEF, D1=32'h0102_0304:
  - FRM_CH=2 with those values;
  - CAN3_WE pulses exactly once with ADDR=16'h0010 and DO=1;
  - FRM_CNT=1.
- Backpressure: FRM_READY=0 for 20 cycles → FRM_VALID and the frame contents stay stable, and no RE/WE strobes occur. The frame is accepted when READY rises.
- Fairness: all four channels pending continuously → frames are delivered with FRM_CH sequence 0,1,2,3,0.
- Parameter check: RD_LAT=3 with a pending frame → CANx_DO is sampled 3 cycles after each RE, and the frame matches the programmed values.
